// File: rtl/fpga_ss_bootloader_pkg.sv
// Shared types for the FTDI-to-slave-serial bitstream loader.
package fpga_ss_bootloader_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_e;

endpackage

// File: rtl/fpga_ss_bootloader_ss_shifter.sv
// Parallel-load serializer with bit counter; dout_o is the registered DIN pin.
// last_o flags that the bit currently on dout_o is the final bit of the word.
module fpga_ss_bootloader_ss_shifter #(
  parameter int DATA_W    = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              shift_i,
  output logic              dout_o,
  output logic              last_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dout_q, dout_d;

  // sreg holds only the bits still to be sent, pre-aligned so the next bit is always at the exit end
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (clr_i) begin
      sreg_d = '0;
      cnt_d  = '0;
      dout_d = 1'b0;
    end else if (load_i) begin
      cnt_d = CNT_W'(DATA_W - 1);
      if (MSB_FIRST) begin
        dout_d = data_i[DATA_W-1];
        sreg_d = data_i << 1;
      end else begin
        dout_d = data_i[0];
        sreg_d = data_i >> 1;
      end
    end else if (shift_i) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (MSB_FIRST) begin
        dout_d = sreg_q[DATA_W-1];
        sreg_d = sreg_q << 1;
      end else begin
        dout_d = sreg_q[0];
        sreg_d = sreg_q >> 1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout_o = dout_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/fpga_ss_bootloader.sv
// Pops words from an FTDI sync-245 FIFO and streams them to an FPGA slave-serial port.
// One word in flight at a time; fpga_done parks the loader, ftdi_gpio_1 aborts to IDLE.
module fpga_ss_bootloader
  import fpga_ss_bootloader_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              ftdi_clk,
  input  logic              rst,
  input  logic              clk,
  input  logic [DATA_W-1:0] ftdi_data,
  input  logic              ftdi_rxf_n,
  output logic              ftdi_rd_n,
  input  logic              ftdi_gpio_0,
  input  logic              ftdi_gpio_1,
  output logic              fpga_bl_clk,
  output logic              fpga_bl_data,
  input  logic              fpga_program_b,
  input  logic              fpga_init_b,
  input  logic              fpga_done,
  output logic              dbg
);

  state_e state_q;
  logic   rd_n_q, bl_clk_q, dbg_q;
  logic   have_data;
  logic   shf_clr, shf_load, shf_shift, shf_last, shf_dout;

  assign have_data = ~ftdi_rxf_n;

  // Shifter controls follow the same priority as the FSM: done, then abort, then normal flow
  assign shf_clr   = ftdi_gpio_1 & ~fpga_done;
  assign shf_load  = (state_q == READ) & have_data & ~fpga_done & ~ftdi_gpio_1;
  assign shf_shift = (state_q == SHIFT_HI) & ~shf_last & ~fpga_done & ~ftdi_gpio_1;

  fpga_ss_bootloader_ss_shifter #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk_i   (ftdi_clk),
    .rst_i   (rst),
    .clr_i   (shf_clr),
    .load_i  (shf_load),
    .data_i  (ftdi_data),
    .shift_i (shf_shift),
    .dout_o  (shf_dout),
    .last_o  (shf_last)
  );

  always_ff @(posedge ftdi_clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_n_q   <= 1'b1;
      bl_clk_q <= 1'b0;
      dbg_q    <= 1'b0;
    end else if (fpga_done) begin
      state_q  <= DONE;
      rd_n_q   <= 1'b1;
      bl_clk_q <= 1'b0;
    end else if (ftdi_gpio_1) begin
      state_q  <= IDLE;
      rd_n_q   <= 1'b1;
      bl_clk_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rd_n_q <= ~have_data;
          if (have_data) state_q <= READ;
        end
        READ: begin
          rd_n_q <= 1'b1;
          if (have_data) begin
            dbg_q   <= ~dbg_q;
            state_q <= SHIFT_LO;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT_LO: begin
          bl_clk_q <= 1'b1;
          state_q  <= SHIFT_HI;
        end
        SHIFT_HI: begin
          bl_clk_q <= 1'b0;
          if (!shf_last) begin
            state_q <= SHIFT_LO;
          end else if (have_data) begin
            // chain straight into the next pop so a full FIFO streams at 33 cycles/word
            rd_n_q  <= 1'b0;
            state_q <= READ;
          end else begin
            state_q <= IDLE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ftdi_rd_n    = rd_n_q;
  assign fpga_bl_clk  = bl_clk_q;
  assign fpga_bl_data = shf_dout;
  assign dbg          = dbg_q;

  logic unused_ok;
  assign unused_ok = ^{clk, ftdi_gpio_0, fpga_program_b, fpga_init_b};

endmodule

// File: tb/tb_fpga_ss_bootloader.sv
// Randomized + directed scoreboard bench: FTDI FIFO model feeds the DUT, monitor checks every CCLK rise.
module tb_fpga_ss_bootloader;

  logic        ftdi_clk = 1'b0;
  logic        clk      = 1'b0;
  logic        rst;
  logic [15:0] ftdi_data;
  logic        ftdi_rxf_n;
  logic        ftdi_rd_n;
  logic        gpio0    = 1'b0;
  logic        gpio1;
  logic        bl_clk, bl_data;
  logic        prog_b   = 1'b1;
  logic        init_b   = 1'b1;
  logic        done;
  logic        dbg;

  always #5 ftdi_clk = ~ftdi_clk;
  always #8 clk = ~clk;

  fpga_ss_bootloader dut (
    .ftdi_clk       (ftdi_clk),
    .rst            (rst),
    .clk            (clk),
    .ftdi_data      (ftdi_data),
    .ftdi_rxf_n     (ftdi_rxf_n),
    .ftdi_rd_n      (ftdi_rd_n),
    .ftdi_gpio_0    (gpio0),
    .ftdi_gpio_1    (gpio1),
    .fpga_bl_clk    (bl_clk),
    .fpga_bl_data   (bl_data),
    .fpga_program_b (prog_b),
    .fpga_init_b    (init_b),
    .fpga_done      (done),
    .dbg            (dbg)
  );

  // FTDI receive FIFO model: stimulus owns wr_ptr, monitor owns rd_ptr
  logic [15:0] mem [256];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        rxf_block;
  assign ftdi_rxf_n = rxf_block | (rd_ptr == wr_ptr);
  assign ftdi_data  = mem[rd_ptr[7:0]];

  int   n_vec = 0;
  int   n_err = 0;
  int   flush_cnt = 0;
  int   flush_seen = 0;
  bit   expect_b2b = 1'b0;
  bit   end_req = 1'b0;
  bit   end_done = 1'b0;

  logic exp_q[$];
  logic dbg_exp;
  logic p_rd_n, p_bl_clk, rxf_s, e;
  logic [15:0] w;
  int   cyc_cnt = 0;
  int   last_pop = 0;
  bit   have_b2b = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Monitor: samples on the falling edge; inputs seen here equal those the previous rising edge saw
  initial begin : monitor
    p_rd_n   = 1'b1;
    p_bl_clk = 1'b0;
    dbg_exp  = 1'b0;
    forever begin
      @(negedge ftdi_clk);
      cyc_cnt++;
      rxf_s = ftdi_rxf_n;
      if (flush_cnt != flush_seen) begin
        exp_q.delete();
        flush_seen = flush_cnt;
      end
      if (rst) begin
        chk("rst_rd_n", ftdi_rd_n, 1);
        chk("rst_bl_clk", bl_clk, 0);
        chk("rst_bl_data", bl_data, 0);
        chk("rst_dbg", dbg, 0);
        exp_q.delete();
        dbg_exp  = 1'b0;
        have_b2b = 1'b0;
      end else begin
        // a word is popped when a one-cycle rd_n pulse met a non-empty FIFO with no done/abort
        if (!p_rd_n && !rxf_s && !done && !gpio1) begin
          w = mem[rd_ptr[7:0]];
          rd_ptr++;
          for (int i = 0; i < 16; i++) exp_q.push_back(w[15-i]);
          dbg_exp = ~dbg_exp;
          if (expect_b2b) begin
            if (have_b2b) chk("b2b_period", cyc_cnt - last_pop, 33);
            have_b2b = 1'b1;
            last_pop = cyc_cnt;
          end else begin
            have_b2b = 1'b0;
          end
        end
        if (bl_clk && !p_bl_clk) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL cclk_spurious: CCLK rose with DIN=%0b but no bit was due (cycle %0d)", bl_data, cyc_cnt);
          end else begin
            e = exp_q.pop_front();
            if (bl_data !== e) begin
              n_err++;
              $display("FAIL din_bit: got %0b, expected %0b (cycle %0d)", bl_data, e, cyc_cnt);
            end
          end
        end
        if (done) chk("done_quiet", {ftdi_rd_n, bl_clk}, 2'b10);
        else if (gpio1) chk("abort_quiet", {ftdi_rd_n, bl_clk, bl_data}, 3'b100);
        if (!p_rd_n) chk("rd_pulse_1cyc", ftdi_rd_n, 1);
        if (!ftdi_rd_n) begin
          chk("rd_needs_data", rxf_s, 0);
          chk("rd_while_shift", exp_q.size(), 0);
        end
        chk("dbg", dbg, dbg_exp);
      end
      if (end_req && !end_done) begin
        chk("bits_left", exp_q.size(), 0);
        chk("words_left", wr_ptr - rd_ptr, 0);
        end_done = 1'b1;
      end
      p_rd_n   = ftdi_rd_n;
      p_bl_clk = bl_clk;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge ftdi_clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr++;
  endtask

  initial begin : stimulus
    rst       = 1'b1;
    rxf_block = 1'b0;
    done      = 1'b0;
    gpio1     = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(4);

    // single word
    push(16'hAA55);
    cyc(40);

    // back-to-back stream
    expect_b2b = 1'b1;
    for (int i = 0; i < 4; i++) push(16'h0031);
    cyc(4 * 33 + 8);
    expect_b2b = 1'b0;
    cyc(4);

    // random words, sometimes in pairs
    for (int i = 0; i < 8; i++) begin
      push(16'($urandom));
      if ($urandom_range(0, 1) == 1) push(16'($urandom));
      cyc($urandom_range(70, 100));
    end

    // FIFO drains during the READ cycle
    push(16'($urandom));
    cyc(1);
    rxf_block = 1'b1;
    cyc(6);
    rxf_block = 1'b0;
    cyc(40);

    // fpga_done as bit 5 is about to be clocked; a queued word must wait
    push(16'hF0C3);
    cyc(12);
    done = 1'b1;
    flush_cnt++;
    push(16'h5A96);
    cyc(10);
    done = 1'b0;
    cyc(40);

    // abort mid-word, then a fresh word in full
    push(16'($urandom));
    cyc(20);
    gpio1 = 1'b1;
    flush_cnt++;
    cyc(3);
    gpio1 = 1'b0;
    cyc(5);
    push(16'h8001);
    cyc(40);

    // reset mid-word
    push(16'($urandom));
    cyc(15);
    rst = 1'b1;
    flush_cnt++;
    cyc(2);
    rst = 1'b0;
    cyc(4);
    push(16'h7FFE);
    cyc(40);

    end_req = 1'b1;
    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
